// File: rtl/pixel_stream_sink.sv
// Pixel stream sink: clips renderer pixels, queues them, and writes them in order to a 320x240x3 frame buffer; also runs a full-screen clear.
// Latency: a pixel accepted at edge E is presented on fb_we/fb_addr/fb_data from edge E+1 onwards, at 1 write/cycle while fb_grant=1.
// Backpressure: ready drops when the FIFO is full or during drain/clear; fb_we holds address/data stable until fb_grant.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   writeEn, x_stream, y_stream,
//   color_stream, ready                renderer pixel input (transfer on writeEn && ready)
//   clear                              clear-screen request (ignored unless in RUN)
//   fb_we, fb_addr, fb_data, fb_grant  frame-buffer write port (write done on fb_we && fb_grant)
//   busy, clear_done, clipped_count    status
module pixel_stream_sink #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int          SCREEN_W    = 320,
    parameter int          SCREEN_H    = 240,
    parameter logic [2:0]  CLEAR_COLOR = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        writeEn,
    input  logic [8:0]  x_stream,
    input  logic [7:0]  y_stream,
    input  logic [2:0]  color_stream,
    output logic        ready,
    input  logic        clear,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [2:0]  fb_data,
    input  logic        fb_grant,
    output logic        busy,
    output logic        clear_done,
    output logic [15:0] clipped_count
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    localparam logic [9:0]      X_LIM     = 10'(SCREEN_W);
    localparam logic [8:0]      Y_LIM     = 9'(SCREEN_H);
    localparam logic [16:0]     LAST_ADDR = 17'(SCREEN_W * SCREEN_H - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [16:0] addr;
        logic [2:0]  color;
    } pix_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q;

    pix_t             fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Output register doubles as the clear address counter in CLEAR,
    // so fb_* always come straight from flops.
    logic             out_vld_q;
    logic [16:0]      out_addr_q;
    logic [2:0]       out_data_q;

    logic             clear_done_q;
    logic [15:0]      clip_cnt_q;
    logic [15:0]      clip_cnt_d;

    // ------------------------------------------------------------------
    // Input side: handshake, clipping, address generation
    // ------------------------------------------------------------------
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        in_range;
    logic        push;
    logic        clip;
    logic        pop;
    logic        out_free;
    logic [16:0] pix_addr;
    pix_t        push_dat;
    pix_t        head_dat;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // ready depends only on flops; no combinational path from writeEn or fb_grant.
    assign ready  = (state_q == ST_RUN) && !fifo_full;
    assign accept = writeEn && ready;

    assign in_range = ({1'b0, x_stream} < X_LIM) && ({1'b0, y_stream} < Y_LIM);
    assign push     = accept && in_range;
    assign clip     = accept && !in_range;

    // Constant multiply; at SCREEN_W=320 this reduces to (y<<8)+(y<<6)+x.
    assign pix_addr = 17'(y_stream) * 17'(SCREEN_W) + 17'(x_stream);

    assign push_dat.addr  = pix_addr;
    assign push_dat.color = color_stream;
    assign head_dat       = fifo_mem_q[rd_ptr_q];

    // Output register can take a new entry when empty or when its write completes now.
    assign out_free = !out_vld_q || fb_grant;
    // In CLEAR the output register carries clear writes; the FIFO is empty there anyway.
    assign pop      = !fifo_empty && out_free && (state_q != ST_CLEAR);

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            out_vld_q    <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                ST_RUN, ST_DRAIN: begin
                    if (pop) begin
                        out_vld_q  <= 1'b1;
                        out_addr_q <= head_dat.addr;
                        out_data_q <= head_dat.color;
                    end else if (out_vld_q && fb_grant) begin
                        out_vld_q <= 1'b0;
                    end

                    if (state_q == ST_RUN) begin
                        if (clear) begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (fifo_empty && !out_vld_q) begin
                        // Everything queued before the clear has been written.
                        state_q    <= ST_CLEAR;
                        out_vld_q  <= 1'b1;
                        out_addr_q <= '0;
                        out_data_q <= CLEAR_COLOR;
                    end
                end

                ST_CLEAR: begin
                    if (fb_grant) begin
                        if (out_addr_q == LAST_ADDR) begin
                            out_vld_q    <= 1'b0;
                            clear_done_q <= 1'b1;
                            state_q      <= ST_RUN;
                        end else begin
                            out_addr_q <= out_addr_q + 17'd1;
                        end
                    end
                end

                default: begin
                    state_q   <= ST_RUN;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Clipped-pixel counter, saturating
    // ------------------------------------------------------------------
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (clip && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_d = clip_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clip_cnt_q <= '0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fb_we         = out_vld_q;
    assign fb_addr       = out_addr_q;
    assign fb_data       = out_data_q;
    assign clear_done    = clear_done_q;
    assign clipped_count = clip_cnt_q;
    assign busy          = (state_q != ST_RUN) || !fifo_empty || out_vld_q;

endmodule
